// File: rtl/aes_ctr_stream.sv
// rtl/aes_ctr_stream.sv - AES counter-mode stream encryptor/decryptor (optional AES_CTR_INC32_EN: GCM inc32 counter)
module aes_ctr_stream #(
    parameter int KEY_BITS   = 192,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KEY_BITS-1:0] key,
    input  logic [127:0]        iv,
    input  logic                load,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data
);
    localparam int NK  = KEY_BITS / 32;
    localparam int NR  = NK + 6;
    localparam int LAT = 2 * NR + 1;
    localparam int NW  = 4 * (NR + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + LAT + 1);

    typedef enum logic {UNKEYED, KEYED} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] pw;
        inv = 8'h01;
        pw  = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, pw);
            pw = gmul(pw, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Round key r lives at bits [128*r +: 128].
    function automatic logic [128*(NR+1)-1:0] key_expand(input logic [KEY_BITS-1:0] k);
        logic [31:0] w [NW];
        logic [31:0] t;
        logic [7:0]  rcon;
        logic [128*(NR+1)-1:0] rk;
        rcon = 8'h01;
        rk   = '0;
        for (int i = 0; i < NW; i++) begin
            if (i < NK) begin
                w[i] = k[KEY_BITS-1-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % NK == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = xtime(rcon);
                end else if (NK > 6 && i % NK == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-NK] ^ t;
            end
        end
        for (int r = 0; r <= NR; r++)
            rk[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    state_t                state_q, state_d;
    logic [KEY_BITS-1:0]   key_q;
    logic [127:0]          ctr_q;
    logic [127:0]          ctr_inc;
    logic [128*(NR+1)-1:0] rk_all;
    logic [127:0]          st_q  [LAT];
    logic [127:0]          st_d  [LAT];
    logic [127:0]          dly_q [LAT];
    logic [127:0]          dly_d [LAT];
    logic [LAT-1:0]        vld_q;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [127:0]          mem [FIFO_DEPTH];
    logic                  load_acc, in_acc, credit_ok, fifo_wr, fifo_rd;
    logic [127:0]          fifo_wdata;

`ifdef AES_CTR_INC32_EN
    assign ctr_inc = {ctr_q[127:32], ctr_q[31:0] + 32'd1};
`else
    assign ctr_inc = ctr_q + 128'd1;
`endif

    assign busy       = (inflight != '0) || (fifo_count != '0);
    assign load_acc   = load && !busy;
    assign credit_ok  = (inflight + fifo_count) < CW'(FIFO_DEPTH);
    assign in_acc     = in_valid && in_ready;
    assign fifo_wr    = vld_q[LAT-1];
    assign fifo_wdata = st_q[LAT-1] ^ dly_q[LAT-1];
    assign fifo_rd    = out_valid && out_ready;
    assign out_valid  = fifo_count != '0;
    assign out_data   = out_valid ? mem[rd_ptr] : '0;
    assign rk_all     = key_expand(key_q);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            UNKEYED: if (load_acc) state_d = KEYED;
            KEYED:   in_ready = !load && credit_ok;
            default: state_d = UNKEYED;
        endcase
    end

    // Cipher pipeline: one stage for the whitening key, then SubBytes/ShiftRows
    // and MixColumns/AddRoundKey as separate stages for every round.
    always_comb begin
        st_d[0]  = ctr_q ^ rk_all[127:0];
        dly_d[0] = in_data;
        for (int r = 1; r <= NR; r++) begin
            st_d[2*r-1] = shift_rows(sub_bytes(st_q[2*r-2]));
            if (r == NR)
                st_d[2*r] = st_q[2*r-1] ^ rk_all[128*r +: 128];
            else
                st_d[2*r] = mix_columns(st_q[2*r-1]) ^ rk_all[128*r +: 128];
        end
        for (int i = 1; i < LAT; i++) dly_d[i] = dly_q[i-1];
    end

    always_ff @(posedge clk) begin
        st_q  <= st_d;
        dly_q <= dly_d;
        if (fifo_wr) mem[wr_ptr] <= fifo_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNKEYED;
            key_q      <= '0;
            ctr_q      <= '0;
            vld_q      <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state_q <= state_d;
            if (load_acc) begin
                key_q <= key;
                ctr_q <= iv;
            end else if (in_acc) begin
                ctr_q <= ctr_inc;
            end
            vld_q <= {vld_q[LAT-2:0], in_acc};
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
            if (in_acc && !fifo_wr)
                inflight <= inflight + CW'(1);
            else if (!in_acc && fifo_wr)
                inflight <= inflight - CW'(1);
            if (fifo_wr && !fifo_rd)
                fifo_count <= fifo_count + CW'(1);
            else if (!fifo_wr && fifo_rd)
                fifo_count <= fifo_count - CW'(1);
        end
    end
endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb/tb_aes_ctr_stream.sv - scoreboard bench for aes_ctr_stream against a textbook AES-CTR model
module tb_aes_ctr_stream;
    localparam int KB  = 192;
    localparam int FD  = 32;
    localparam int MNK = KB / 32;
    localparam int MNR = MNK + 6;
    localparam logic [KB-1:0] K1  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0]  IV1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [KB-1:0] K2  = 192'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da5;
    localparam logic [127:0]  IV2 = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_CTR_INC32_EN
    localparam logic [127:0]  WRAP_CTR = 128'hffffffffffffffffffffffff00000000;
`else
    localparam logic [127:0]  WRAP_CTR = 128'h0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KB-1:0] key;
    logic [127:0]  iv;
    logic          load;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  out_data;

    aes_ctr_stream #(.KEY_BITS(KB), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .iv(iv), .load(load), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int            tests = 0;
    int            fails = 0;
    logic [127:0]  sb [$];
    logic [127:0]  last_out;
    logic [7:0]    sbox_t [256];
    logic [KB-1:0] m_key;
    logic [127:0]  m_ctr;
    bit            rnd_ready = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Table built by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [127:0] aes_enc(input logic [KB-1:0] k, input logic [127:0] blk);
        logic [31:0]  w [4*(MNR+1)];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4*(MNR+1); i++) begin
            if (i < MNK) begin
                w[i] = k[KB-1-32*i -: 32];
            end else begin
                tmp = w[i-1];
                if (i % MNK == 0) begin
                    tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (MNK > 6 && i % MNK == 4) begin
                    tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                end
                w[i] = w[i-MNK] ^ tmp;
            end
        end
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= MNR; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i + 4*(i%4)) % 16]];
            for (int c = 0; c < 4; c++) begin
                if (rnd == MNR) begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end else begin
                    s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] next_ctr(input logic [127:0] c);
`ifdef AES_CTR_INC32_EN
        return {c[127:32], c[31:0] + 32'd1};
`else
        return c + 128'd1;
`endif
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic load_key(input logic [KB-1:0] k, input logic [127:0] v, input bit expect_accept);
        load = 1'b1;
        key  = k;
        iv   = v;
        @(negedge clk);
        check("load_busy", 128'(busy), 128'(!expect_accept));
        check("in_ready_during_load", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        load = 1'b0;
        if (expect_accept) begin
            m_key = k;
            m_ctr = v;
        end
    endtask

    task automatic send(input logic [127:0] data);
        int n;
        in_valid = 1'b1;
        in_data  = data;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 500) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready 0 for 500 cycles, required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        sb.push_back(aes_enc(m_key, m_ctr) ^ data);
        m_ctr    = next_ctr(m_ctr);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        for (n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 5000 && sb.size() != 0; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain_empty", 128'(sb.size()), 128'(0));
        check("drain_busy", 128'(busy), 128'(0));
        check("drain_out_valid", 128'(out_valid), 128'(0));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                last_out = out_data;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got %h, required no output", out_data);
                end else begin
                    check("out_data", out_data, sb.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int n;
        int acc;
        build_sbox();
        rst_n = 1'b0; key = '0; iv = '0; load = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        m_key = '0; m_ctr = '0; last_out = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        @(posedge clk); #1; rst_n = 1'b1;

        in_valid = 1'b1;
        in_data  = rnd128();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("in_ready_unkeyed", 128'(in_ready), 128'(0));
        end
        @(posedge clk); #1; in_valid = 1'b0;

        out_ready = 1'b1;
        load_key(K1, IV1, 1'b1);
        send('0);
        wait_valid(n);
        check("fips_latency", 128'(n), 128'(25));
        check("fips_vector", out_data, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        drain();

        load_key(K2, IV2, 1'b1);
        send({128{1'b1}});
        wait_valid(n);
        check("vector2", out_data, 128'h0604d65103c7b5dafcbf27cc478143ff);
        drain();

        in_valid = 1'b1;
        in_data  = rnd128();
        load_key(K1, rnd128(), 1'b1);
        send(in_data);

        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(rnd128());
        end
        drain();
        rnd_ready = 1'b0;

        @(posedge clk); #1;
        out_ready = 1'b0;
        acc       = 0;
        in_valid  = 1'b1;
        in_data   = rnd128();
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(aes_enc(m_key, m_ctr) ^ in_data);
                m_ctr = next_ctr(m_ctr);
                acc++;
                @(posedge clk); #1;
                in_data = rnd128();
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 128'(acc), 128'(FD));
        check("bp_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1; out_ready = 1'b1;
        drain();

        load_key(K1, {128{1'b1}}, 1'b1);
        send('0);
        send('0);
        drain();
        check("wrap_block2", last_out, aes_enc(K1, WRAP_CTR));

        load_key(K1, rnd128(), 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(rnd128());
        load_key(K2, rnd128(), 1'b0);
        for (int i = 0; i < 4; i++) send(rnd128());
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(rnd128());
        repeat (30) @(negedge clk);
        check("pre_reset_valid", 128'(out_valid), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (40) @(negedge clk);
        @(posedge clk); #1;
        load_key(K2, rnd128(), 1'b1);
        for (int i = 0; i < 5; i++) send(rnd128());
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
